// File: rtl/snake_cmd_decoder.sv
// Snake draw-command decoder: buffers the command stream, paints point/rect
// commands into the 32x24 tile framebuffer and pairs two-word line/text
// commands for the overlay renderer.
module snake_cmd_decoder #(
    parameter int unsigned CMD_WIDTH     = 32,
    parameter int unsigned H_LOGIC_WIDTH = 5,
    parameter int unsigned V_LOGIC_WIDTH = 5,
    parameter int unsigned H_LOGIC_MAX   = 31,
    parameter int unsigned V_LOGIC_MAX   = 23,
    parameter int unsigned COLOR_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [CMD_WIDTH-1:0]                   cmd,
    input  logic                                   cmd_vld,
    output logic                                   fb_we,
    output logic [V_LOGIC_WIDTH+H_LOGIC_WIDTH-1:0] fb_addr,
    output logic [COLOR_WIDTH-1:0]                 fb_data,
    output logic [CMD_WIDTH-1:0]                   ovl_cmd0,
    output logic [CMD_WIDTH-1:0]                   ovl_cmd1,
    output logic                                   ovl_vld,
    output logic                                   busy,
    output logic                                   err,
    output logic                                   ovf
);

    localparam int unsigned H_W     = H_LOGIC_WIDTH;
    localparam int unsigned V_W     = V_LOGIC_WIDTH;
    localparam int unsigned C_W     = COLOR_WIDTH;
    localparam int unsigned ADDR_W  = V_W + H_W;
    localparam int unsigned FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = FIFO_AW + 1;

    localparam logic [H_W-1:0] X_MAX   = H_W'(H_LOGIC_MAX);
    localparam logic [V_W-1:0] Y_MAX   = V_W'(V_LOGIC_MAX);
    localparam logic [H_W:0]   X_LIM   = (H_W+1)'(H_LOGIC_MAX);
    localparam logic [V_W:0]   Y_LIM   = (V_W+1)'(V_LOGIC_MAX);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POINT = 2'd1,
        S_FILL  = 2'd2
    } state_t;

    // FIFO storage and pointers
    logic [CMD_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 fifo_empty, fifo_full;
    logic                 push, pop;
    logic [CMD_WIDTH-1:0] head;

    // Engine state
    state_t         state_q, state_d;
    logic [H_W-1:0] cx_q, cx_d, x0_q, x0_d, x1_q, x1_d;
    logic [V_W-1:0] cy_q, cy_d, y1_q, y1_d;
    logic [C_W-1:0] col_q, col_d;
    logic           pend_q, pend_d;

    // Registered outputs
    logic                 fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]    fb_addr_q, fb_addr_d;
    logic [C_W-1:0]       fb_data_q, fb_data_d;
    logic [CMD_WIDTH-1:0] ovl0_q, ovl0_d, ovl1_q, ovl1_d;
    logic                 ovl_vld_q, ovl_vld_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 ovf_q, ovf_d;

    // Decoded fields of the FIFO head
    logic [3:0]     op;
    logic [H_W-1:0] hx0, hx1, hx1c;
    logic [V_W-1:0] hy0, hy1, hy1c;
    logic [C_W-1:0] pcol, rcol;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_FULL);
    assign head       = mem_q[rd_ptr_q];

    assign op   = head[31:28];
    assign hx0  = head[27 -: H_W];
    assign hy0  = head[22 -: V_W];
    assign pcol = head[17 -: C_W];
    assign hx1  = head[17 -: H_W];
    assign hy1  = head[12 -: V_W];
    assign rcol = head[7  -: C_W];
    assign hx1c = ({1'b0, hx1} > X_LIM) ? X_MAX : hx1;
    assign hy1c = ({1'b0, hy1} > Y_LIM) ? Y_MAX : hy1;

    // Command engine: decode at pop, then point gap or raster fill
    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        x0_d      = x0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        col_d     = col_q;
        pend_d    = pend_q;
        fb_we_d   = 1'b0;
        fb_addr_d = fb_addr_q;
        fb_data_d = fb_data_q;
        ovl0_d    = ovl0_q;
        ovl1_d    = ovl1_q;
        ovl_vld_d = 1'b0;
        err_d     = 1'b0;
        pop       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    case (op)
                        4'h0: begin
                            state_d = S_POINT;
                            if (({1'b0, hx0} <= X_LIM) && ({1'b0, hy0} <= Y_LIM)) begin
                                fb_we_d   = 1'b1;
                                fb_addr_d = {hy0, hx0};
                                fb_data_d = pcol;
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        4'h1: begin
                            if ((hx0 > hx1c) || (hy0 > hy1c)) begin
                                err_d = 1'b1;
                            end else begin
                                // First cell is written at pop time to meet the 2-cycle latency
                                fb_we_d   = 1'b1;
                                fb_addr_d = {hy0, hx0};
                                fb_data_d = rcol;
                                x0_d      = hx0;
                                x1_d      = hx1c;
                                y1_d      = hy1c;
                                col_d     = rcol;
                                if (hx0 != hx1c) begin
                                    cx_d    = hx0 + H_W'(1);
                                    cy_d    = hy0;
                                    state_d = S_FILL;
                                end else if (hy0 != hy1c) begin
                                    cx_d    = hx0;
                                    cy_d    = hy0 + V_W'(1);
                                    state_d = S_FILL;
                                end
                            end
                        end
                        4'h9, 4'hA: begin
                            if (!head[0]) begin
                                ovl0_d = head;
                                pend_d = 1'b1;
                                err_d  = pend_q;
                            end else begin
                                if (pend_q && (ovl0_q[31:28] == op)) begin
                                    ovl1_d    = head;
                                    ovl_vld_d = 1'b1;
                                end else begin
                                    err_d = 1'b1;
                                end
                                pend_d = 1'b0;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_POINT: state_d = S_IDLE;
            S_FILL: begin
                fb_we_d   = 1'b1;
                fb_addr_d = {cy_q, cx_q};
                fb_data_d = col_q;
                if (cx_q != x1_q) begin
                    cx_d = cx_q + H_W'(1);
                end else begin
                    cx_d = x0_q;
                    if (cy_q != y1_q) begin
                        cy_d = cy_q + V_W'(1);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO bookkeeping; a push into a full FIFO survives only if a pop frees a slot
    always_comb begin
        push     = cmd_vld & (~fifo_full | pop);
        ovf_d    = ovf_q | (cmd_vld & fifo_full & ~pop);
        wr_ptr_d = push ? (wr_ptr_q + FIFO_AW'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + FIFO_AW'(1)) : rd_ptr_q;
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
        busy_d = (cnt_d != '0) | (state_d != S_IDLE);
    end

    // FIFO word storage
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cmd;
        end
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            col_q     <= '0;
            pend_q    <= 1'b0;
            fb_we_q   <= 1'b0;
            fb_addr_q <= '0;
            fb_data_q <= '0;
            ovl0_q    <= '0;
            ovl1_q    <= '0;
            ovl_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            x0_q      <= x0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            col_q     <= col_d;
            pend_q    <= pend_d;
            fb_we_q   <= fb_we_d;
            fb_addr_q <= fb_addr_d;
            fb_data_q <= fb_data_d;
            ovl0_q    <= ovl0_d;
            ovl1_q    <= ovl1_d;
            ovl_vld_q <= ovl_vld_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
        end
    end

    assign fb_we    = fb_we_q;
    assign fb_addr  = fb_addr_q;
    assign fb_data  = fb_data_q;
    assign ovl_cmd0 = ovl0_q;
    assign ovl_cmd1 = ovl1_q;
    assign ovl_vld  = ovl_vld_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_snake_cmd_decoder.sv
// Scoreboard bench for snake_cmd_decoder: a cycle-costed reference model
// predicts every framebuffer write, overlay pulse and error pulse with the
// cycle it must appear; a negedge monitor compares against the DUT.
module tb_snake_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_vld = 1'b0;
    logic [31:0] cmd = '0;
    logic        fb_we;
    logic [9:0]  fb_addr;
    logic [7:0]  fb_data;
    logic [31:0] ovl_cmd0, ovl_cmd1;
    logic        ovl_vld, busy, err, ovf;

    always #5 clk = ~clk;

    snake_cmd_decoder dut (
        .clk      (clk),
        .rst      (rst),
        .cmd      (cmd),
        .cmd_vld  (cmd_vld),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .ovl_cmd0 (ovl_cmd0),
        .ovl_cmd1 (ovl_cmd1),
        .ovl_vld  (ovl_vld),
        .busy     (busy),
        .err      (err),
        .ovf      (ovf)
    );

    typedef struct { int t; logic [9:0] addr; logic [7:0] data; } wr_t;
    typedef struct { int t; logic [31:0] w0; logic [31:0] w1; } ovl_t;

    wr_t         wq[$];
    ovl_t        oq[$];
    int          eq[$];
    logic [31:0] mq[$];

    int          cyc = 0;
    int          free_at = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_w = '0;
    bit          exp_busy_cur = 1'b0, exp_busy_nxt = 1'b0;
    bit          exp_ovf_cur = 1'b0, exp_ovf_nxt = 1'b0;
    bit          mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: effect of one popped command at cycle c
    task automatic model_exec(input logic [31:0] w, input int c);
        int   x0, y0, x1, y1, k;
        logic [3:0] op;
        wr_t  e;
        ovl_t o;
        op      = w[31:28];
        free_at = c + 1;
        case (op)
            4'h0: begin
                x0 = int'(w[27:23]);
                y0 = int'(w[22:18]);
                free_at = c + 2;
                if (x0 <= 31 && y0 <= 23) begin
                    e.t = c + 1; e.addr = 10'(y0 * 32 + x0); e.data = w[17:10];
                    wq.push_back(e);
                end else begin
                    eq.push_back(c + 1);
                end
            end
            4'h1: begin
                x0 = int'(w[27:23]);
                y0 = int'(w[22:18]);
                x1 = int'(w[17:13]); if (x1 > 31) x1 = 31;
                y1 = int'(w[12:8]);  if (y1 > 23) y1 = 23;
                if (x0 > x1 || y0 > y1) begin
                    eq.push_back(c + 1);
                end else begin
                    k = 0;
                    for (int y = y0; y <= y1; y++) begin
                        for (int x = x0; x <= x1; x++) begin
                            k++;
                            e.t = c + k; e.addr = 10'(y * 32 + x); e.data = w[7:0];
                            wq.push_back(e);
                        end
                    end
                    free_at = c + k;
                end
            end
            4'h9, 4'hA: begin
                if (w[0] == 1'b0) begin
                    if (pend) eq.push_back(c + 1);
                    pend   = 1'b1;
                    pend_w = w;
                end else begin
                    if (pend && pend_w[31:28] == op) begin
                        o.t = c + 1; o.w0 = pend_w; o.w1 = w;
                        oq.push_back(o);
                    end else begin
                        eq.push_back(c + 1);
                    end
                    pend = 1'b0;
                end
            end
            default: eq.push_back(c + 1);
        endcase
    endtask

    // One clock of stimulus plus the matching model update
    task automatic step(input bit v, input logic [31:0] w, input bit r);
        int sz;
        bit do_pop;
        @(posedge clk);
        #1;
        cyc++;
        rst = r; cmd_vld = v; cmd = w;
        exp_busy_cur = exp_busy_nxt;
        exp_ovf_cur  = exp_ovf_nxt;
        if (r) begin
            mq.delete();
            pend = 1'b0; free_at = 0;
            while (wq.size() > 0 && wq[wq.size()-1].t > cyc) void'(wq.pop_back());
            while (oq.size() > 0 && oq[oq.size()-1].t > cyc) void'(oq.pop_back());
            while (eq.size() > 0 && eq[eq.size()-1] > cyc) void'(eq.pop_back());
            exp_busy_nxt = 1'b0;
            exp_ovf_nxt  = 1'b0;
        end else begin
            sz     = mq.size();
            do_pop = (sz > 0) && (cyc >= free_at);
            if (do_pop) model_exec(mq.pop_front(), cyc);
            if (v) begin
                if (sz < 16 || do_pop) mq.push_back(w);
                else exp_ovf_nxt = 1'b1;
            end
            exp_busy_nxt = (mq.size() != 0) || (free_at > cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq.size() != 0 || free_at > cyc) && n < 5000) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        idle(3);
    endtask

    function automatic logic [31:0] rand_cmd();
        logic [31:0] r;
        logic [4:0]  x0, y0, x1, y1;
        logic [3:0]  o;
        int          sel;
        r   = $urandom();
        sel = $urandom_range(0, 9);
        x0  = 5'($urandom_range(0, 31));
        y0  = 5'($urandom_range(0, 27));
        x1  = x0 + 5'($urandom_range(0, 4));
        y1  = y0 + 5'($urandom_range(0, 3));
        if (sel <= 3) return {4'h0, x0, y0, r[7:0], r[17:8]};
        if (sel <= 5) return {4'h1, x0, y0, x1, y1, r[7:0]};
        if (sel <= 8) return {(r[31] ? 4'h9 : 4'hA), r[27:1], (sel != 6)};
        o = 4'($urandom_range(2, 15));
        if (o == 4'h9 || o == 4'hA) o = 4'hF;
        return {o, r[27:0]};
    endfunction

    // Monitor: compare DUT outputs against the scoreboard every cycle
    always @(negedge clk) begin : monitor
        bit ew, ee, eo;
        if (mon_en) begin
            ew = (wq.size() > 0) && (wq[0].t == cyc);
            check("fb_we", 32'(fb_we), 32'(ew));
            if (ew) begin
                if (fb_we) begin
                    check("fb_addr", 32'(fb_addr), 32'(wq[0].addr));
                    check("fb_data", 32'(fb_data), 32'(wq[0].data));
                end
                void'(wq.pop_front());
            end
            ee = (eq.size() > 0) && (eq[0] == cyc);
            check("err", 32'(err), 32'(ee));
            if (ee) void'(eq.pop_front());
            eo = (oq.size() > 0) && (oq[0].t == cyc);
            check("ovl_vld", 32'(ovl_vld), 32'(eo));
            if (eo) begin
                if (ovl_vld) begin
                    check("ovl_cmd0", ovl_cmd0, oq[0].w0);
                    check("ovl_cmd1", ovl_cmd1, oq[0].w1);
                end
                void'(oq.pop_front());
            end
            check("busy", 32'(busy), 32'(exp_busy_cur));
            check("ovf", 32'(ovf), 32'(exp_ovf_cur));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] clr;
        clr = {4'h1, 5'd0, 5'd0, 5'd31, 5'd23, 8'hff};

        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        mon_en = 1'b1;
        step(1'b0, '0, 1'b1);
        idle(2);
        @(negedge clk);
        check("reset_fb_addr", 32'(fb_addr), 32'd0);
        check("reset_fb_data", 32'(fb_data), 32'd0);
        check("reset_ovl_cmd0", ovl_cmd0, 32'd0);
        check("reset_ovl_cmd1", ovl_cmd1, 32'd0);

        // Single point, idle engine
        step(1'b1, {4'h0, 5'd3, 5'd4, 8'h0f, 10'b0}, 1'b0);
        idle(5);

        // Clear screen followed by a 9-word init burst
        step(1'b1, clr, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, rand_cmd(), 1'b0);
        drain();

        // 20 points back-to-back during a fill: overflow, sticky ovf
        step(1'b1, clr, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b1, {4'h0, 5'(i), 5'(i % 24), 8'(i + 1), 10'b0}, 1'b0);
        drain();
        idle(10);
        step(1'b0, '0, 1'b1);
        idle(3);

        // Reset in the middle of a fill
        step(1'b1, clr, 1'b0);
        idle(50);
        step(1'b0, '0, 1'b1);
        idle(5);

        // Pairing and error cases
        step(1'b1, {4'h9, 10'd0, 9'd440, 8'h02, 1'b0}, 1'b0);
        step(1'b1, {4'h9, 10'd639, 9'd442, 8'h02, 1'b1}, 1'b0);
        idle(3);
        step(1'b1, {4'hA, 20'h12345, 8'h01}, 1'b0);
        idle(3);
        step(1'b1, {4'h1, 5'd5, 5'd0, 5'd2, 5'd3, 8'h44}, 1'b0);
        idle(3);
        step(1'b1, {4'h7, 28'h0}, 1'b0);
        idle(3);
        // Pair with a point interleaved between its words
        step(1'b1, {4'hA, 27'h0abcdef, 1'b0}, 1'b0);
        step(1'b1, {4'h0, 5'd31, 5'd23, 8'h5a, 10'b0}, 1'b0);
        step(1'b1, {4'hA, 27'h1234567, 1'b1}, 1'b0);
        drain();

        // Randomized traffic
        for (int i = 0; i < 2000; i++)
            step(($urandom_range(0, 99) < 40), rand_cmd(), 1'b0);
        drain();

        checks++;
        if (wq.size() != 0 || oq.size() != 0 || eq.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d/%0d/%0d pending expected 0/0/0",
                     wq.size(), oq.size(), eq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
